// File: rtl/noise_sched.sv
// Round-robin scheduler sharing one white-noise generator among NCH sample channels.
// Each channel has a free-running period counter; a grant steps the generator once and captures its byte.
module noise_sched #(
    parameter int NCH   = 4,
    parameter int DIV_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_ch,
    input  logic [DIV_W-1:0]   cfg_period,
    input  logic [NCH-1:0]     ovr_clr,
    input  logic               reseed,
    output logic               gen_ena,
    output logic               gen_rst,
    input  logic [7:0]         gen_out,
    output logic [NCH*8-1:0]   ch_sample,
    output logic [NCH-1:0]     ch_strobe,
    output logic [NCH-1:0]     overrun,
    output logic               busy
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_STEP = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;
    localparam logic [1:0] S_SEED = 2'd3;

    logic [DIV_W-1:0] period [NCH];
    logic [DIV_W-1:0] cnt    [NCH];
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   pending_nx;
    logic [NCH-1:0]   ovr_set;
    logic [NCH-1:0]   grant_oh;
    logic [NCH-1:0]   clr_v;
    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [PW-1:0]    rr;
    logic [PW-1:0]    grant;
    logic [PW-1:0]    pick;
    logic             seed_lat;
    logic             seed_req;
    logic             take;

    // Scan downwards so the nearest requester after 'last' is the one left in sel.
    function automatic logic [PW-1:0] rr_pick(input logic [NCH-1:0] req, input logic [PW-1:0] last);
        logic [PW-1:0] sel;
        int            idx;
        sel = last;
        for (int i = NCH; i >= 1; i--) begin
            idx = (int'(last) + i) % NCH;
            if (req[idx]) sel = PW'(idx);
        end
        return sel;
    endfunction

    always_comb begin
        tick = '0;
        for (int k = 0; k < NCH; k++)
            tick[k] = (period[k] != '0) && (cnt[k] == '0);
    end

    assign seed_req = reseed || seed_lat;
    assign pick     = rr_pick(pending, rr);
    assign take     = (state == S_IDLE) && !seed_req && (pending != '0);
    assign grant_oh = take ? (NCH'(1) << pick) : '0;
    assign clr_v    = grant_oh | {NCH{state == S_SEED}};

    // A tick on a channel being cleared this cycle re-arms it without counting as an overrun.
    always_comb begin
        pending_nx = '0;
        ovr_set    = '0;
        for (int k = 0; k < NCH; k++) begin
            ovr_set[k]    = tick[k] & pending[k] & ~clr_v[k];
            pending_nx[k] = (period[k] != '0) & (tick[k] | (pending[k] & ~clr_v[k]));
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (seed_req)
                    state_nx = S_SEED;
                else if (pending != '0)
                    state_nx = S_STEP;
            end
            S_STEP:  state_nx = S_CAPT;
            S_CAPT:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                period[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (cfg_we && (int'(cfg_ch) == k)) begin
                    period[k] <= cfg_period;
                    cnt[k]    <= (cfg_period == '0) ? '0 : cfg_period - 1'b1;
                end else if (tick[k]) begin
                    cnt[k] <= period[k] - 1'b1;
                end else if (cnt[k] != '0) begin
                    cnt[k] <= cnt[k] - 1'b1;
                end
            end
        end
    end

    // gen_ena/gen_rst/busy are registered from the next state so they line up with STEP/SEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr        <= PW'(NCH - 1);
            grant     <= '0;
            pending   <= '0;
            overrun   <= '0;
            seed_lat  <= 1'b0;
            gen_ena   <= 1'b0;
            gen_rst   <= 1'b0;
            busy      <= 1'b0;
            ch_strobe <= '0;
            ch_sample <= '0;
        end else begin
            state     <= state_nx;
            pending   <= pending_nx;
            overrun   <= (overrun & ~ovr_clr) | ovr_set;
            gen_ena   <= (state_nx == S_STEP);
            gen_rst   <= (state_nx == S_SEED);
            busy      <= (state_nx != S_IDLE);
            ch_strobe <= '0;
            if (take) begin
                grant <= pick;
                rr    <= pick;
            end
            if (state == S_IDLE)
                seed_lat <= 1'b0;
            else if (reseed && ((state == S_STEP) || (state == S_CAPT)))
                seed_lat <= 1'b1;
            if (state == S_CAPT) begin
                ch_strobe[grant]                <= 1'b1;
                ch_sample[int'(grant)*8 +: 8]   <= gen_out;
            end
        end
    end

endmodule

// File: tb/tb_noise_sched.sv
// Randomised self-checking bench for noise_sched with an event-scheduled reference model
// and a behavioural noise generator that yields a fresh random byte on every step.
module tb_noise_sched;
    localparam int NCH   = 4;
    localparam int DIV_W = 16;
    localparam int VW    = 3 + 2*NCH + 8*NCH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_ch = '0;
    logic [DIV_W-1:0] cfg_period = '0;
    logic [NCH-1:0]   ovr_clr = '0;
    logic             reseed = 1'b0;
    logic             gen_ena;
    logic             gen_rst;
    logic [7:0]       gen_out;
    logic [NCH*8-1:0] ch_sample;
    logic [NCH-1:0]   ch_strobe;
    logic [NCH-1:0]   overrun;
    logic             busy;
    logic [7:0]       gen_val = 8'h00;
    logic [VW-1:0]    obs;

    noise_sched #(.NCH(NCH), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .ovr_clr(ovr_clr), .reseed(reseed), .gen_ena(gen_ena), .gen_rst(gen_rst), .gen_out(gen_out),
        .ch_sample(ch_sample), .ch_strobe(ch_strobe), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    assign gen_out = gen_val;
    always @(posedge clk) begin
        if (gen_rst)      gen_val <= 8'hA5;
        else if (gen_ena) gen_val <= 8'($urandom);
    end

    assign obs = {gen_ena, gen_rst, busy, ch_strobe, overrun, ch_sample};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-channel period/phase plus absolute cycle numbers of scheduled events.
    int             cyc, free_at, ena_at, rst_at, stb_at, stb_ch, cap_at, rrp;
    bit             seed_req;
    int             mp [NCH];
    int             ms [NCH];
    bit             mpend [NCH];
    logic [NCH-1:0] movr;
    logic [7:0]     msamp [NCH];
    logic [7:0]     g_in;

    task automatic model_reset();
        cyc = 0; free_at = 0; ena_at = -1; rst_at = -1; stb_at = -1; stb_ch = 0; cap_at = -1;
        rrp = NCH - 1; seed_req = 0; movr = '0;
        for (int k = 0; k < NCH; k++) begin
            mp[k] = 0; ms[k] = 0; mpend[k] = 0; msamp[k] = 8'h00;
        end
    endtask

    task automatic model_advance();
        bit tk [NCH];
        bit idle, seedc, clr, oset;
        int g;
        idle  = (cyc >= free_at);
        seedc = (rst_at == cyc);
        g     = -1;
        for (int k = 0; k < NCH; k++)
            tk[k] = (mp[k] != 0) && (((cyc - ms[k]) % mp[k]) == mp[k] - 1);
        if (cyc == cap_at) msamp[stb_ch] = g_in;
        if (idle) begin
            if (reseed || seed_req) begin
                rst_at = cyc + 1; free_at = cyc + 2; seed_req = 0;
            end else begin
                for (int i = 1; i <= NCH; i++) begin
                    int idx;
                    idx = (rrp + i) % NCH;
                    if (g < 0 && mpend[idx]) g = idx;
                end
                if (g >= 0) begin
                    ena_at = cyc + 1; cap_at = cyc + 2; stb_at = cyc + 3; free_at = cyc + 3;
                    stb_ch = g; rrp = g;
                end
            end
        end else if (reseed && !seedc) begin
            seed_req = 1;
        end
        for (int k = 0; k < NCH; k++) begin
            clr  = (k == g) || seedc;
            oset = tk[k] && mpend[k] && !clr;
            mpend[k] = (mp[k] != 0) && (tk[k] || (mpend[k] && !clr));
            movr[k]  = (movr[k] && !ovr_clr[k]) || oset;
        end
        if (cfg_we && int'(cfg_ch) < NCH) begin
            mp[cfg_ch] = int'(cfg_period);
            ms[cfg_ch] = cyc + 1;
        end
        cyc++;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NCH*8-1:0] s;
        logic [NCH-1:0]   e_stb;
        for (int k = 0; k < NCH; k++) s[8*k +: 8] = msamp[k];
        e_stb = (stb_at == cyc) ? (NCH'(1) << stb_ch) : '0;
        return {ena_at == cyc, rst_at == cyc, cyc < free_at, e_stb, movr, s};
    endfunction

    task automatic step();
        g_in = gen_out;
        @(posedge clk); #1;
        model_advance();
        cfg_we = 1'b0; reseed = 1'b0; ovr_clr = '0;
    endtask

    task automatic cfg(input int ch, input int p);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_period = DIV_W'(p);
        step();
    endtask

    task automatic do_reset();
        cfg_we = 1'b0; reseed = 1'b0; ovr_clr = '0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        cfg_we = 1'b0; reseed = 1'b0; ovr_clr = '0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (ch_sample !== '0) begin n_bad++; $display("FAIL reset_sample observed=%h required=0", ch_sample); end
        n_cmp++;
        if ({gen_ena, gen_rst, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl observed=%b required=000", {gen_ena, gen_rst, busy}); end
        n_cmp++;
        if ({ch_strobe, overrun} !== '0) begin n_bad++; $display("FAIL reset_flags observed=%b required=0", {ch_strobe, overrun}); end
        rst_n = 1'b1;
        model_reset();
        repeat (5) begin
            step();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL reset_idle cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
        end
    endtask

    task automatic test_single();
        int last_ena, last_stb, nstb;
        last_ena = -100; last_stb = -1; nstb = 0;
        do_reset();
        cfg(0, 4);
        repeat (48) begin
            step();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL single_model cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
            if (gen_ena) last_ena = cyc;
            if (ch_strobe !== '0) begin
                n_cmp++;
                if (ch_strobe !== 4'b0001) begin n_bad++; $display("FAIL single_chan observed=%b required=0001", ch_strobe); end
                n_cmp++;
                if (cyc - last_ena !== 2) begin n_bad++; $display("FAIL single_ena_lead observed=%0d required=2", cyc - last_ena); end
                if (last_stb >= 0) begin
                    n_cmp++;
                    if (cyc - last_stb !== 4) begin n_bad++; $display("FAIL single_gap observed=%0d required=4", cyc - last_stb); end
                end
                last_stb = cyc; nstb++;
            end
        end
        n_cmp++;
        if (nstb < 10) begin n_bad++; $display("FAIL single_count observed=%0d required>=10", nstb); end
        n_cmp++;
        if (overrun !== '0) begin n_bad++; $display("FAIL single_overrun observed=%b required=0", overrun); end
    endtask

    task automatic test_rr();
        int seq_ch [$];
        int seq_t  [$];
        do_reset();
        for (int k = 0; k < NCH; k++) cfg(k, 12);
        repeat (60) begin
            step();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL rr_model cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
            for (int k = 0; k < NCH; k++)
                if (ch_strobe[k]) begin seq_ch.push_back(k); seq_t.push_back(cyc); end
        end
        n_cmp++;
        if (seq_ch.size() < 12) begin n_bad++; $display("FAIL rr_count observed=%0d required>=12", seq_ch.size()); end
        for (int i = 0; i < seq_ch.size(); i++) begin
            n_cmp++;
            if (seq_ch[i] !== i % NCH) begin n_bad++; $display("FAIL rr_order idx=%0d observed=%0d required=%0d", i, seq_ch[i], i % NCH); end
            if (i > 0) begin
                n_cmp++;
                if (seq_t[i] - seq_t[i-1] !== 3) begin n_bad++; $display("FAIL rr_gap idx=%0d observed=%0d required=3", i, seq_t[i] - seq_t[i-1]); end
            end
        end
        n_cmp++;
        if (overrun !== '0) begin n_bad++; $display("FAIL rr_overrun observed=%b required=0", overrun); end
    endtask

    task automatic test_overrun();
        int  seen_at, n;
        seen_at = -1;
        do_reset();
        cfg(0, 1);
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL ovr_model cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
            if (overrun[0] && seen_at < 0) seen_at = i;
        end
        n_cmp++;
        if (seen_at < 0) begin n_bad++; $display("FAIL ovr_set observed=%b required=overrun[0]=1 within 4", overrun); end
        n = 0;
        while (gen_ena !== 1'b1 && n < 10) begin step(); n++; end
        n_cmp++;
        if (gen_ena !== 1'b1) begin n_bad++; $display("FAIL ovr_wait_step observed=%b required=1", gen_ena); end
        ovr_clr = 4'b0001;
        step();
        n_cmp++;
        if (overrun[0] !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins observed=%b required=1", overrun[0]); end
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL ovr_model2 cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
        cfg(0, 0);
        repeat (3) step();
        ovr_clr = 4'b0001;
        step();
        n_cmp++;
        if (overrun[0] !== 1'b0) begin n_bad++; $display("FAIL ovr_clear observed=%b required=0", overrun[0]); end
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL ovr_model3 cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
    endtask

    task automatic test_reseed();
        int n;
        do_reset();
        cfg(0, 4);
        n = 0;
        while (gen_ena !== 1'b1 && n < 20) begin step(); n++; end
        n_cmp++;
        if (gen_ena !== 1'b1) begin n_bad++; $display("FAIL seed_wait_step observed=%b required=1", gen_ena); end
        reseed = 1'b1;
        step();
        step();
        n_cmp++;
        if ({ch_strobe, gen_rst} !== 5'b00010) begin n_bad++; $display("FAIL seed_capt_first observed=%b required=00010", {ch_strobe, gen_rst}); end
        step();
        n_cmp++;
        if (gen_rst !== 1'b1) begin n_bad++; $display("FAIL seed_late_pulse observed=%b required=1", gen_rst); end
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL seed_model cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
        step();
        n_cmp++;
        if (gen_rst !== 1'b0) begin n_bad++; $display("FAIL seed_late_end observed=%b required=0", gen_rst); end
        n = 0;
        while (busy !== 1'b0 && n < 20) begin step(); n++; end
        reseed = 1'b1;
        step();
        n_cmp++;
        if ({gen_rst, gen_ena} !== 2'b10) begin n_bad++; $display("FAIL seed_idle_pulse observed=%b required=10", {gen_rst, gen_ena}); end
        step();
        n_cmp++;
        if (gen_rst !== 1'b0) begin n_bad++; $display("FAIL seed_idle_end observed=%b required=0", gen_rst); end
        repeat (20) begin
            step();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL seed_after cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
        end
    endtask

    task automatic test_disable();
        int nstb;
        nstb = 0;
        do_reset();
        cfg(0, 4);
        repeat (20) step();
        n_cmp++;
        if (obs !== exp_vec()) begin n_bad++; $display("FAIL dis_run cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
        cfg(0, 0);
        repeat (6) step();
        repeat (30) begin
            step();
            if (ch_strobe !== '0) nstb++;
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL dis_model cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
        end
        n_cmp++;
        if (nstb !== 0) begin n_bad++; $display("FAIL dis_strobes observed=%0d required=0", nstb); end
    endtask

    task automatic test_random();
        do_reset();
        repeat (2000) begin
            if ($urandom_range(15) == 0) begin
                cfg_we = 1'b1; cfg_ch = 3'($urandom_range(7)); cfg_period = DIV_W'($urandom_range(24));
            end
            reseed  = ($urandom_range(39) == 0);
            ovr_clr = ($urandom_range(7) == 0) ? NCH'($urandom) : '0;
            step();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL rand_model cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
            n_cmp++;
            if (!$onehot0(ch_strobe)) begin n_bad++; $display("FAIL rand_onehot observed=%b required=onehot0", ch_strobe); end
        end
    endtask

    task automatic test_reset_mid();
        int n, first;
        first = -1;
        do_reset();
        cfg(0, 3);
        n = 0;
        while (gen_ena !== 1'b1 && n < 20) begin step(); n++; end
        n_cmp++;
        if (gen_ena !== 1'b1) begin n_bad++; $display("FAIL mid_wait_step observed=%b required=1", gen_ena); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gen_ena, busy, ch_strobe} !== '0) begin n_bad++; $display("FAIL mid_async observed=%b required=0", {gen_ena, busy, ch_strobe}); end
        @(posedge clk); #1;
        n_cmp++;
        if ({ch_strobe, ch_sample} !== '0) begin n_bad++; $display("FAIL mid_no_strobe observed=%h required=0", {ch_strobe, ch_sample}); end
        rst_n = 1'b1;
        model_reset();
        cfg(1, 9);
        cfg(0, 8);
        repeat (24) begin
            step();
            n_cmp++;
            if (obs !== exp_vec()) begin n_bad++; $display("FAIL mid_model cyc=%0d observed=%h required=%h", cyc, obs, exp_vec()); end
            if (ch_strobe !== '0 && first < 0) first = int'(ch_strobe);
        end
        n_cmp++;
        if (first !== 1) begin n_bad++; $display("FAIL mid_ch0_first observed=%0d required=1", first); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d observed=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_rr();
        test_overrun();
        test_reseed();
        test_disable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
